mem_arb: RTL and testbench

Single-port memory arbiter and stall sequencer for the 5-stage pipeline. It shares one external memory bus between the IF-stage instruction fetch and the MEM-stage load/store, and holds each transaction until the bus acknowledges or a watchdog expires. It also drives the 6-bit pipeline stall vector (pc, if_id, id_ex, ex_mem, mem_wb, wb) that freezes the stages behind a waiting requester.

---
 rtl/mem_arb.sv | 107 ++++++++++
 tb/tb_mem_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Single-port memory arbiter for the 5-stage pipeline: shares one external bus
// between instruction fetch and load/store, with a watchdog and stall vector.
module mem_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        bus_err,
    output logic        bus_cs,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [5:0]  stall
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    state_t     state;
    logic       last_mem;
    logic [7:0] wd_count;
    logic       busy;
    logic       timeout;
    logic       done;

    assign busy    = (state != IDLE);
    // A real bus_ack in the final watchdog cycle takes priority over the timeout.
    assign timeout = busy && !bus_ack && (wd_count == 8'(TIMEOUT - 1));
    assign done    = busy && (bus_ack || timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_mem  <= 1'b0;
            wd_count  <= 8'd0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_sel   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    wd_count <= 8'd0;
                    // After a MEM completion a waiting fetch wins, so IF cannot starve.
                    if (mem_req && (!last_mem || !if_req)) begin
                        state     <= MEM_BUSY;
                        bus_we    <= mem_we;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                        bus_sel   <= mem_sel;
                    end else if (if_req) begin
                        state     <= IF_BUSY;
                        bus_we    <= 1'b0;
                        bus_addr  <= if_addr;
                        bus_wdata <= 32'd0;
                        bus_sel   <= 4'hF;
                    end
                end
                IF_BUSY, MEM_BUSY: begin
                    if (done) begin
                        state    <= IDLE;
                        last_mem <= (state == MEM_BUSY);
                    end else begin
                        wd_count <= wd_count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_cs    = busy;
    assign if_ack    = (state == IF_BUSY) && done;
    assign mem_ack   = (state == MEM_BUSY) && done;
    assign bus_err   = timeout;
    assign if_rdata  = (if_ack && !timeout) ? bus_rdata : 32'd0;
    assign mem_rdata = (mem_ack && !timeout) ? bus_rdata : 32'd0;

    // MEM stall freezes everything up to mem_wb; it dominates a pending fetch.
    always_comb begin
        stall = 6'b000000;
        if (rst)
            stall = 6'b000000;
        else if (mem_req && !mem_ack)
            stall = 6'b011111;
        else if (if_req && !if_ack)
            stall = 6'b000011;
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: one DUT at the default watchdog and one at TIMEOUT=4,
// both driven by the same requester and bus stimulus.
module tb_mem_arb;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ack, mem_ack, bus_err, bus_cs, bus_we;
    logic [3:0]  bus_sel;
    logic [5:0]  stall;

    logic [31:0] t4_if_rdata, t4_mem_rdata, t4_bus_addr, t4_bus_wdata;
    logic        t4_if_ack, t4_mem_ack, t4_bus_err, t4_bus_cs, t4_bus_we;
    logic [3:0]  t4_bus_sel;
    logic [5:0]  t4_stall;

    int vectors = 0;
    int miscompares = 0;

    mem_arb dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err),
        .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stall(stall)
    );

    mem_arb #(.TIMEOUT(4)) dut_t4 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(t4_if_rdata), .if_ack(t4_if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_rdata(t4_mem_rdata), .mem_ack(t4_mem_ack), .bus_err(t4_bus_err),
        .bus_cs(t4_bus_cs), .bus_we(t4_bus_we), .bus_addr(t4_bus_addr), .bus_wdata(t4_bus_wdata),
        .bus_sel(t4_bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stall(t4_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0;
        mem_wdata = 0; mem_sel = 0; bus_rdata = 0; bus_ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        // Power-on reset: every output low.
        clear_inputs();
        rst = 1;
        #3;
        vectors++;
        if ({bus_cs, if_ack, mem_ack, bus_err, bus_we, stall} !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0", {bus_cs, if_ack, mem_ack, bus_err, bus_we, stall});
        end
        vectors++;
        if ({bus_addr, bus_wdata, bus_sel, if_rdata, mem_rdata} !== 132'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h expected 0", {bus_addr, bus_wdata, bus_sel});
        end
        @(posedge clk); #1;
        rst = 0;

        // Reset in the middle of a MEM transaction.
        mem_req = 1; mem_addr = 32'h40; mem_sel = 4'hF;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({bus_cs, stall} !== 7'b1_011111) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_busy: got %b expected 1011111", {bus_cs, stall});
        end
        #2 rst = 1;
        #1;
        vectors++;
        if ({bus_cs, mem_ack, stall} !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_drop: got %b expected 0", {bus_cs, mem_ack, stall});
        end
        @(posedge clk); #1;
        rst = 0; mem_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus_cs, mem_ack, if_ack} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL rst_after_idle[%0d]: got %b expected 000", i, {bus_cs, mem_ack, if_ack});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch();
        do_reset();
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        vectors++;
        if ({bus_cs, stall} !== 7'b0_000011) begin
            miscompares++;
            $display("[TB] FAIL fetch_T: got %b expected 0000011", {bus_cs, stall});
        end
        @(posedge clk); #1;
        bus_ack = 1; bus_rdata = 32'h00000013;
        @(negedge clk);
        vectors++;
        if ({bus_cs, if_ack, mem_ack, bus_err, bus_we, bus_sel} !== 9'b1_1_0_0_0_1111) begin
            miscompares++;
            $display("[TB] FAIL fetch_ack_ctrl: got %b expected 110001111", {bus_cs, if_ack, mem_ack, bus_err, bus_we, bus_sel});
        end
        vectors++;
        if ({bus_addr, if_rdata} !== {32'h100, 32'h00000013}) begin
            miscompares++;
            $display("[TB] FAIL fetch_ack_data: got %h expected 0000010000000013", {bus_addr, if_rdata});
        end
        @(posedge clk); #1;
        if_req = 0; bus_ack = 0;
        @(negedge clk);
        vectors++;
        if ({bus_cs, if_ack, if_rdata, stall} !== 40'd0) begin
            miscompares++;
            $display("[TB] FAIL fetch_after: got %h expected 0", {bus_cs, if_ack, if_rdata, stall});
        end
        // bus_ack while idle must not produce an ack.
        @(posedge clk); #1;
        bus_ack = 1;
        @(negedge clk);
        vectors++;
        if ({bus_cs, if_ack, mem_ack, bus_err} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL idle_ack_ignored: got %b expected 0000", {bus_cs, if_ack, mem_ack, bus_err});
        end
        @(posedge clk); #1;
        bus_ack = 0;
    endtask

    task automatic test_store_wait();
        do_reset();
        mem_req = 1; mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF; mem_sel = 4'b0011;
        @(negedge clk);
        for (int b = 1; b <= 4; b++) begin
            @(posedge clk); #1;
            bus_ack = (b == 4);
            @(negedge clk);
            vectors++;
            if ({bus_cs, bus_we, bus_sel, bus_addr, bus_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF}) begin
                miscompares++;
                $display("[TB] FAIL store_bus[%0d]: got %h expected %h", b,
                         {bus_cs, bus_we, bus_sel, bus_addr, bus_wdata}, {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF});
            end
            vectors++;
            if ({mem_ack, bus_err} !== {(b == 4), 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL store_ack[%0d]: got %b expected %b", b, {mem_ack, bus_err}, {(b == 4), 1'b0});
            end
            if (b < 4) begin
                vectors++;
                if (stall !== 6'b011111) begin
                    miscompares++;
                    $display("[TB] FAIL store_stall[%0d]: got %b expected 011111", b, stall);
                end
            end
        end
        @(posedge clk); #1;
        mem_req = 0; mem_we = 0; bus_ack = 0;
        @(negedge clk);
        vectors++;
        if (bus_cs !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL store_done_idle: got %b expected 0", bus_cs);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr;
        logic [1:0]  exp_acks;
        logic [5:0]  exp_stall;
        do_reset();
        if_req = 1; if_addr = 32'h100;
        mem_req = 1; mem_we = 0; mem_addr = 32'h3000; mem_sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 0) ? 32'h3000 : 32'h100;
            for (int p = 0; p < 3; p++) begin
                if (k != 0 || p != 0) begin
                    @(posedge clk); #1;
                end
                bus_ack = (p == 2);
                @(negedge clk);
                exp_stall = (k % 2 == 0 && p == 2) ? 6'b000011 : 6'b011111;
                vectors++;
                if (stall !== exp_stall) begin
                    miscompares++;
                    $display("[TB] FAIL contend_stall[%0d.%0d]: got %b expected %b", k, p, stall, exp_stall);
                end
                if (p == 1) begin
                    vectors++;
                    if ({bus_cs, bus_addr} !== {1'b1, exp_addr}) begin
                        miscompares++;
                        $display("[TB] FAIL contend_grant[%0d]: got %h expected %h", k, {bus_cs, bus_addr}, {1'b1, exp_addr});
                    end
                end
                if (p == 2) begin
                    exp_acks = (k % 2 == 0) ? 2'b01 : 2'b10;
                    vectors++;
                    if ({if_ack, mem_ack} !== exp_acks) begin
                        miscompares++;
                        $display("[TB] FAIL contend_ack[%0d]: got %b expected %b", k, {if_ack, mem_ack}, exp_acks);
                    end
                end
            end
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1; mem_we = 0; mem_addr = 32'h500; mem_sel = 4'hF; bus_rdata = 32'h55555555;
        @(negedge clk);
        for (int b = 1; b <= 4; b++) begin
            @(posedge clk); #1;
            @(negedge clk);
            vectors++;
            if ({t4_bus_cs, t4_mem_ack, t4_bus_err} !== {1'b1, (b == 4), (b == 4)}) begin
                miscompares++;
                $display("[TB] FAIL timeout_ctrl[%0d]: got %b expected %b", b,
                         {t4_bus_cs, t4_mem_ack, t4_bus_err}, {1'b1, (b == 4), (b == 4)});
            end
        end
        vectors++;
        if (t4_mem_rdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL timeout_rdata: got %h expected 00000000", t4_mem_rdata);
        end
        @(posedge clk); #1;
        mem_req = 0;
        @(negedge clk);
        vectors++;
        if ({t4_bus_cs, t4_mem_ack, t4_bus_err} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL timeout_idle: got %b expected 000", {t4_bus_cs, t4_mem_ack, t4_bus_err});
        end
    endtask

    task automatic test_collision();
        do_reset();
        mem_req = 1; mem_we = 0; mem_addr = 32'h600; mem_sel = 4'hF;
        @(negedge clk);
        for (int b = 1; b <= 4; b++) begin
            @(posedge clk); #1;
            bus_ack = (b == 4);
            bus_rdata = (b == 4) ? 32'hCAFEF00D : 32'h0;
            @(negedge clk);
        end
        vectors++;
        if ({t4_mem_ack, t4_bus_err} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL collide_ctrl: got %b expected 10", {t4_mem_ack, t4_bus_err});
        end
        vectors++;
        if (t4_mem_rdata !== 32'hCAFEF00D) begin
            miscompares++;
            $display("[TB] FAIL collide_rdata: got %h expected cafef00d", t4_mem_rdata);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_wait();
        test_contention();
        test_timeout();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
